// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM arbiter.
//   DATA_W_DEF / DEPTH_DEF : default data width and RAM depth (words)
//   port_t                 : requester identity (fetch or data)
//   addr_legal()           : word alignment and range check for a byte address
package bram_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // A byte address is legal when it is word aligned and falls inside the RAM.
  // The comparison is done at 34 bits so 4*depth can never overflow.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/bram_arb_sel.sv
// Combinational grant selection for the two requesters.
// Configuration macro: BRAM_ARB_RR_EN
//   defined   : round-robin, the port not granted last wins on contention
//   undefined : fixed priority, data over fetch (last is ignored)
// Ports:
//   f_valid, d_valid : request valids (already masked by reset)
//   last             : port granted most recently
//   gnt_f, gnt_d     : one-hot (or zero) grant
module bram_arb_sel
  import bram_arb_pkg::*;
(
  input  logic  f_valid,
  input  logic  d_valid,
  input  port_t last,
  output logic  gnt_f,
  output logic  gnt_d
);

`ifdef BRAM_ARB_RR_EN
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (f_valid && d_valid) begin
      if (last == PORT_D) begin
        gnt_f = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else begin
      gnt_f = f_valid;
      gnt_d = d_valid;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  assign gnt_d = d_valid;
  assign gnt_f = f_valid && !d_valid;
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Arbiter sharing one single-ported 1-cycle-read block RAM between the
// instruction-fetch port (read only) and the data load/store port.
// At most one access is granted per cycle; the response (read data, store
// acknowledge or error) returns to the owner exactly one cycle later.
// Misaligned or out-of-range accesses never reach the RAM and answer err=1.
// Configuration macro: BRAM_ARB_RR_EN (round-robin when defined, otherwise
// fixed data-over-fetch priority without a last-grant register).
// Ports:
//   clk, rst                              : clock, sync active-high reset
//   f_valid/f_ready/f_addr                : fetch request handshake
//   f_rvalid/f_rdata/f_err                : fetch response
//   d_valid/d_ready/d_we/d_addr/d_wdata   : data request handshake
//   d_rvalid/d_rdata/d_err                : data response
//   ram_we/ram_rst/ram_addr/ram_di        : RAM control and write data
//   ram_dout                              : RAM read data (cycle after address)
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [31:0]       f_addr,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_we,
  output logic              ram_rst,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);

  logic        f_req;
  logic        d_req;
  logic        gnt_f;
  logic        gnt_d;
  logic        any_gnt;
  logic        gnt_legal;
  logic        gnt_store;
  logic [31:0] gnt_addr;
  logic [31:0] addr_shadow;
  port_t       last_gnt;

  // Nothing is granted while reset is held.
  assign f_req = f_valid && !rst;
  assign d_req = d_valid && !rst;

  bram_arb_sel u_sel (
    .f_valid (f_req),
    .d_valid (d_req),
    .last    (last_gnt),
    .gnt_f   (gnt_f),
    .gnt_d   (gnt_d)
  );

  assign f_ready = gnt_f;
  assign d_ready = gnt_d;

`ifdef BRAM_ARB_RR_EN
  // Reset value "fetch last" makes data win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_F;
    end else if (any_gnt) begin
      last_gnt <= gnt_d ? PORT_D : PORT_F;
    end
  end
`else
  assign last_gnt = PORT_F;
`endif

  // Stage 0: grant cycle, request presented to the RAM.
  assign any_gnt   = gnt_f || gnt_d;
  assign gnt_addr  = gnt_d ? d_addr : f_addr;
  assign gnt_legal = any_gnt && addr_legal(gnt_addr, DEPTH);
  assign gnt_store = gnt_d && d_we;

  // The shadow keeps the RAM address steady on idle or rejected cycles so
  // the RAM output does not change needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_shadow <= '0;
    end else if (gnt_legal) begin
      addr_shadow <= gnt_addr;
    end
  end

  assign ram_addr = gnt_legal ? gnt_addr : addr_shadow;
  assign ram_we   = gnt_legal && gnt_store;
  assign ram_di   = d_wdata;
  assign ram_rst  = rst;

  // Stage 1: response register, RAM data arrives alongside it.
  logic        resp_pend;
  port_t       resp_port;
  logic        resp_err;
  logic        resp_is_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pend     <= 1'b0;
      resp_port     <= PORT_F;
      resp_err      <= 1'b0;
      resp_is_store <= 1'b0;
    end else begin
      resp_pend     <= any_gnt;
      resp_port     <= gnt_d ? PORT_D : PORT_F;
      resp_err      <= any_gnt && !gnt_legal;
      resp_is_store <= gnt_store;
    end
  end

  logic              resp_live;
  logic [DATA_W-1:0] resp_rdata;

  // A response pending when reset rises is suppressed in that same cycle.
  assign resp_live  = resp_pend && !rst;
  assign resp_rdata = (resp_live && !resp_err && !resp_is_store) ? ram_dout : '0;

  assign f_rvalid = resp_live && (resp_port == PORT_F);
  assign d_rvalid = resp_live && (resp_port == PORT_D);
  assign f_rdata  = (resp_port == PORT_F) ? resp_rdata : '0;
  assign d_rdata  = (resp_port == PORT_D) ? resp_rdata : '0;
  assign f_err    = f_rvalid && resp_err;
  assign d_err    = d_rvalid && resp_err;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios followed by
// randomized traffic, with a scoreboard per response port.
module tb_bram_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              fv, dv, dwe;
  logic [31:0]       fa, da;
  logic [DATA_W-1:0] dwd;
  logic              f_ready, f_rvalid, f_err;
  logic              d_ready, d_rvalid, d_err;
  logic [DATA_W-1:0] f_rdata, d_rdata;
  logic              ram_we, ram_rst;
  logic [31:0]       ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] ram_dout;

  bram_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_valid  (fv),
    .f_ready  (f_ready),
    .f_addr   (fa),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .d_valid  (dv),
    .d_ready  (d_ready),
    .d_we     (dwe),
    .d_addr   (da),
    .d_wdata  (dwd),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .ram_we   (ram_we),
    .ram_rst  (ram_rst),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Block RAM environment: 256 x 32, read-first, output reset by ram_rst.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr[9:2]] <= ram_di;
    end
    if (ram_rst) ram_dout <= '0;
    else         ram_dout <= mem[ram_addr[9:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: memory image, last-granted port, last legal RAM address.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  logic [31:0] ref_mem [256];
  bit          m_last_d;
  logic [31:0] m_shadow;
  bit          obs_f, obs_d, obs_drv;

  // One clock cycle: inputs already driven; predict the grant at the
  // negedge, compare the request side, queue the expected response.
  task automatic cycle();
    bit          gf, gd, lg, st, acc_f, acc_d;
    logic [31:0] ga;
    exp_t        e;
    @(negedge clk);
    gf = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      if (fv && dv) begin
`ifdef BRAM_ARB_RR_EN
        if (m_last_d) gf = 1'b1;
        else          gd = 1'b1;
`else
        gd = 1'b1;
`endif
      end else begin
        gf = fv;
        gd = dv;
      end
    end
    chk("f_ready", 32'(f_ready), 32'(gf));
    chk("d_ready", 32'(d_ready), 32'(gd));
    ga = gd ? da : fa;
    lg = (gf || gd) && (ga % 4 == 0) && (ga < 32'(4 * DEPTH));
    st = gd && dwe;
    chk("ram_we", 32'(ram_we), 32'(lg && st));
    chk("ram_addr", ram_addr, lg ? ga : m_shadow);
    if (lg && st) chk("ram_di", ram_di, dwd);
    if (rst) begin
      chk("rst_f_rdata", f_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_f_err", 32'(f_err), 32'h0);
      chk("rst_d_err", 32'(d_err), 32'h0);
      chk("ram_rst", 32'(ram_rst), 32'h1);
    end
    obs_f   = f_ready;
    obs_d   = d_ready;
    obs_drv = d_rvalid;
    if (gf || gd) begin
      e.cyc   = cyc;
      e.err   = !lg;
      e.rdata = (lg && !st) ? ref_mem[ga[9:2]] : 32'h0;
      if (gd) dq.push_back(e);
      else    fq.push_back(e);
      if (lg && st) ref_mem[ga[9:2]] = dwd;
      if (lg) m_shadow = ga;
      m_last_d = gd;
    end
    if (rst) begin
      m_last_d = 1'b0;
      m_shadow = 32'h0;
    end
    acc_f = gf;
    acc_d = gd;
    @(posedge clk);
    #1;
    if (acc_f) fv = 1'b0;
    if (acc_d) dv = 1'b0;
  endtask

  // Response monitor: an entry queued in an earlier cycle must appear now.
  always @(negedge clk) begin
    if (fq.size() != 0 && fq[0].cyc < cyc) begin
      chk("f_rvalid", 32'(f_rvalid), 32'h1);
      chk("f_rdata", f_rdata, fq[0].rdata);
      chk("f_err", 32'(f_err), 32'(fq[0].err));
      void'(fq.pop_front());
    end else begin
      chk("f_rvalid_idle", 32'(f_rvalid), 32'h0);
    end
    if (dq.size() != 0 && dq[0].cyc < cyc) begin
      chk("d_rvalid", 32'(d_rvalid), 32'h1);
      chk("d_rdata", d_rdata, dq[0].rdata);
      chk("d_err", 32'(d_err), 32'(dq[0].err));
      void'(dq.pop_front());
    end else begin
      chk("d_rvalid_idle", 32'(d_rvalid), 32'h0);
    end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'h400 + 32'($urandom_range(0, 1023));
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    logic [3:0] pat_exp;
    fv = 1'b0; fa = '0; dv = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    m_last_d = 1'b0;
    m_shadow = 32'h0;
    @(posedge clk);
    #1;

    // Reset, with requests asserted to show ready stays low.
    fv = 1'b1; fa = 32'h8; dv = 1'b1; da = 32'hC;
    for (int i = 0; i < 3; i++) cycle();
    fv = 1'b0; dv = 1'b0;
    rst = 1'b0;
    cycle();

    // Store then load back-to-back, then a fetch of the same word.
    dv = 1'b1; dwe = 1'b1; da = 32'h10; dwd = 32'hDEADBEEF; cycle();
    dv = 1'b1; dwe = 1'b0; da = 32'h10; cycle();
    cycle();
    fv = 1'b1; fa = 32'h10; cycle();
    chk("fetch_ready_same_cycle", 32'(obs_f), 32'h1);
    cycle();

    // Contention: both valid for four cycles.
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      fv = 1'b1; fa = 32'h0; dv = 1'b1; dwe = 1'b0; da = 32'h4;
      cycle();
      pat[3-i] = obs_d;
    end
`ifdef BRAM_ARB_RR_EN
    pat_exp = 4'b1010;
`else
    pat_exp = 4'b1111;
`endif
    chk("contention_grants", 32'(pat), 32'(pat_exp));
    fv = 1'b0; dv = 1'b0;
    cycle();

    // Misaligned store and out-of-range load, then full readback.
    dv = 1'b1; dwe = 1'b1; da = 32'h402; dwd = 32'h12345678; cycle();
    dv = 1'b1; dwe = 1'b0; da = 32'h400; cycle();
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      dv = 1'b1; dwe = 1'b0; da = 32'(i) << 2;
      cycle();
    end
    cycle();

    // Reset arriving while a load response is pending.
    dv = 1'b1; dwe = 1'b0; da = 32'h20; cycle();
    rst = 1'b1;
    fq.delete();
    dq.delete();
    cycle();
    chk("rst_drops_d_rvalid", 32'(obs_drv), 32'h0);
    rst = 1'b0;
    fv = 1'b1; fa = 32'h8; dv = 1'b1; dwe = 1'b0; da = 32'hC;
    cycle();
    chk("post_reset_first_grant_d", 32'(obs_d), 32'h1);
    dv = 1'b0;
    cycle();
    cycle();

    // Randomized traffic; requests hold until accepted.
    for (int n = 0; n < 600; n++) begin
      if (!fv && $urandom_range(0, 2) != 0) begin
        fv = 1'b1;
        fa = rand_addr();
      end
      if (!dv && $urandom_range(0, 2) != 0) begin
        dv  = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        da  = rand_addr();
        dwd = $urandom;
      end
      cycle();
    end
    fv = 1'b0; dv = 1'b0;
    cycle();
    cycle();
    chk("f_queue_drained", 32'(fq.size()), 32'h0);
    chk("d_queue_drained", 32'(dq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
